weight_loader: RTL
==================

# weight_loader

Streams packed filter weights from the 32-bit host bus into the systolic array's per-column weight FIFOs. It unpacks bus words into DATA_W-bit weights and asserts the one-hot column enable for the filter being loaded. It counts weights per filter and filters per job, then signals completion. It sits between the AXI slave and the systolic array, and replaces hand-driven weight_en/weight_in sequencing with a configured, back-pressured load engine.

## Interface
- DATA_W, 16, weight width; BUS_W must be an integer multiple of it
- BUS_W, 32, host word width; LANES = BUS_W/DATA_W weights per word
- COLS, 32, systolic columns, one filter per column
- MAX_DIM, 25, maximum weights per filter (5x5 kernel)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  high in IDLE only
- cfg_dim  in  $clog2(MAX_DIM+1)  weights per filter
- cfg_num_filter  in  $clog2(COLS+1)  filters in this job
- cfg_col_base  in  $clog2(COLS)  column that receives the first filter
- abort  in  1  cancel the current job
- s_data  in  BUS_W  packed weights; lane 0 is bits DATA_W-1:0
- s_valid / s_ready  in / out  1  word handshake
- weight_out  out  DATA_W  current weight
- weight_valid  out  1  weight_out is valid this cycle
- weight_en  out  COLS  one-hot column enable, qualified by weight_valid
- busy  out  1  state is LOAD
- done  out  1  one-cycle pulse after the last weight
- err_cfg  out  1  one-cycle pulse on a rejected configuration

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - cfg_ready=1. On cfg_valid the block checks the request.
  - Reject if cfg_dim==0, cfg_dim>MAX_DIM, cfg_num_filter==0, or cfg_col_base+cfg_num_filter>COLS. A reject pulses err_cfg for 1 cycle and the block stays in IDLE.
  - Otherwise it latches dim, num_filter and col_base, clears w_cnt and f_cnt, and moves to LOAD.
- LOAD:
  - A one-word buffer holds the current word and a lane index.
  - Each cycle the buffer is non-empty, the block emits lane[idx] with weight_valid=1 and weight_en = 1<<(col_base+f_cnt), then increments w_cnt and idx.
  - When idx reaches LANES-1, the word is consumed.
  - When w_cnt reaches dim-1, the remaining lanes of the word are discarded. w_cnt clears and f_cnt increments. Every filter starts on a fresh word, so a filter takes ceil(dim/LANES) words.
  - s_ready = (buffer empty) OR (the current emit consumes or discards the word), provided further words remain in the job. s_ready is 0 once the last word of the last filter has been accepted.
  - When the last weight of filter num_filter-1 is emitted, the FSM moves to DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- abort (any state) and rst take effect on the next edge: IDLE, buffer empty, counters cleared, all outputs 0 except cfg_ready=1. No done pulse is issued. Partially loaded columns are not undone; the array owner must reload them.
- cfg_valid is ignored outside IDLE.

## Timing
- Reset values: weight_out=0, weight_valid=0, weight_en=0, s_ready=0, busy=0, done=0, err_cfg=0, cfg_ready=1.
- Accepting cfg_valid at edge t: busy=1 and s_ready=1 from t+1.
- Word accepted at edge t: its lane 0 appears on the registered weight_out/weight_valid at t+1 and lane 1 at t+2.
- Throughput: one weight per cycle while s_valid is held high. No bubble between words or between filters.
- done asserts the cycle after the last weight_valid. cfg_ready returns the cycle after that.
- abort and a word handshake in the same cycle: abort wins and the word is dropped.
- weight_en is 0 whenever weight_valid=0.

## Structure
- weight_loader_pkg: state enum (IDLE, LOAD, DONE) and the config-check function.
- Sub-module word_unpacker: the one-word buffer, lane index and ready logic, parametrised by DATA_W and BUS_W.
- Counters and FSM live in weight_loader.

## Test plan
- Normal job: dim=25, num=2, base=0, 26 words back-to-back.
  - Required: 50 consecutive weight_valid cycles, weight_en=0x1 for 25 of them then 0x2 for 25.
  - The upper halves of words 12 and 25 are discarded.
  - done pulses once, 1 cycle after the 50th weight.
- Backpressure: same job with s_valid toggled pseudo-randomly.
  - Required: weights match the reference sequence exactly, with no loss or duplication, and gaps appear only on weight_valid.
- Bad configs: dim=0; dim=26; num=0; base=31 with num=2.
  - Required: each gives one err_cfg pulse, busy stays 0 and s_ready stays 0.
- Abort mid-filter: abort after weight 7 of filter 1.
  - Required: weight_valid=0 and weight_en=0 next cycle, no done pulse.
  - A following dim=9, num=1, base=5 job completes correctly with weight_en=0x20.
- rst asserted mid-load: all outputs reach their reset values next cycle, then a fresh job loads correctly.
- Edge sizes: dim=1, num=32, base=0, 32 words.
  - Required: one weight per word, weight_en walking 0x1 through 0x80000000, done after the 32nd weight.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// Shared constants, FSM state encodings and configuration helpers for the weight loader.
// Everything here is parameter-agnostic so the top can pass its own sizes in.
package weight_loader_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int BUS_W_DEF   = 32;
    localparam int COLS_DEF    = 32;
    localparam int MAX_DIM_DEF = 25;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A job is legal when every filter fits the kernel limit and the column span fits the array.
    function automatic logic cfg_ok(input int dim, input int num, input int base,
                                    input int max_dim, input int cols);
        return (dim != 0) && (dim <= max_dim) && (num != 0) && (base + num <= cols);
    endfunction

    // Every filter starts on a fresh bus word.
    function automatic int job_words(input int dim, input int num, input int lanes);
        return num * ((dim + lanes - 1) / lanes);
    endfunction

endpackage

// File: rtl/weight_loader_word_unpacker.sv
// One-word buffer that hands out DATA_W-bit lanes of a BUS_W-bit host word, one per cycle.
// Handshake: a word moves when s_valid and s_ready are both high at a rising edge; clear beats it.
module word_unpacker #(
    parameter int DATA_W = 16,
    parameter int BUS_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              more,
    input  logic              filter_end,
    input  logic [BUS_W-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              emit,
    output logic [DATA_W-1:0] lane
);

    localparam int LANES = BUS_W / DATA_W;
    localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic [BUS_W-1:0]             word;
    logic [LANES-1:0][DATA_W-1:0] lanes;
    logic [IW-1:0]                idx;
    logic                         full;
    logic                         consume;

    assign lanes   = word;
    assign lane    = lanes[idx];
    assign emit    = full;
    // The word is done either at its last lane or when the filter ends early inside it.
    assign consume = full && ((idx == IW'(LANES - 1)) || filter_end);
    assign s_ready = (!full || consume) && more;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word <= '0;
            idx  <= '0;
            full <= 1'b0;
        end else if (s_valid && s_ready) begin
            word <= s_data;
            idx  <= '0;
            full <= 1'b1;
        end else if (consume) begin
            idx  <= '0;
            full <= 1'b0;
        end else if (full) begin
            idx  <= idx + IW'(1);
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Configured load engine: unpacks host words into weights and steers them to one column per filter.
// Counts weights per filter and filters per job, then pulses done; abort returns to IDLE at once.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BUS_W   = BUS_W_DEF,
    parameter int COLS    = COLS_DEF,
    parameter int MAX_DIM = MAX_DIM_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [$clog2(MAX_DIM+1)-1:0] cfg_dim,
    input  logic [$clog2(COLS+1)-1:0]    cfg_num_filter,
    input  logic [$clog2(COLS)-1:0]      cfg_col_base,
    input  logic                         abort,
    input  logic [BUS_W-1:0]             s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [DATA_W-1:0]            weight_out,
    output logic                         weight_valid,
    output logic [COLS-1:0]              weight_en,
    output logic                         busy,
    output logic                         done,
    output logic                         err_cfg,
    output logic [1:0]                   fsm_state
);

    localparam int LANES  = BUS_W / DATA_W;
    localparam int DIM_W  = $clog2(MAX_DIM + 1);
    localparam int NUM_W  = $clog2(COLS + 1);
    localparam int BASE_W = $clog2(COLS);
    localparam int WL_W   = $clog2(COLS * ((MAX_DIM + LANES - 1) / LANES) + 1);

    logic [1:0]        state;
    logic [DIM_W-1:0]  dim_q;
    logic [NUM_W-1:0]  num_q;
    logic [BASE_W-1:0] base_q;
    logic [DIM_W-1:0]  w_cnt;
    logic [NUM_W-1:0]  f_cnt;
    logic [WL_W-1:0]   words_left;
    logic              last_q;

    logic              emit;
    logic [DATA_W-1:0] lane;
    logic              filter_end;
    logic              last_filter;
    logic              more;
    logic [NUM_W-1:0]  col_sel;

    assign filter_end  = emit && (w_cnt == dim_q - DIM_W'(1));
    assign last_filter = (f_cnt == num_q - NUM_W'(1));
    assign more        = (state == ST_LOAD) && (words_left != '0);
    assign col_sel     = NUM_W'(base_q) + f_cnt;

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state == ST_LOAD);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

    word_unpacker #(
        .DATA_W (DATA_W),
        .BUS_W  (BUS_W)
    ) u_unpacker (
        .clk        (clk),
        .rst        (rst),
        .clear      (abort),
        .more       (more),
        .filter_end (filter_end),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .emit       (emit),
        .lane       (lane)
    );

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state        <= ST_IDLE;
            dim_q        <= '0;
            num_q        <= '0;
            base_q       <= '0;
            w_cnt        <= '0;
            f_cnt        <= '0;
            words_left   <= '0;
            last_q       <= 1'b0;
            weight_out   <= '0;
            weight_valid <= 1'b0;
            weight_en    <= '0;
            err_cfg      <= 1'b0;
        end else begin
            err_cfg      <= 1'b0;
            last_q       <= 1'b0;
            weight_valid <= emit;
            weight_out   <= emit ? lane : '0;
            weight_en    <= emit ? (COLS'(1) << col_sel) : '0;
            if (s_valid && s_ready) begin
                words_left <= words_left - WL_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_ok(int'(cfg_dim), int'(cfg_num_filter), int'(cfg_col_base),
                                   MAX_DIM, COLS)) begin
                            dim_q      <= cfg_dim;
                            num_q      <= cfg_num_filter;
                            base_q     <= cfg_col_base;
                            w_cnt      <= '0;
                            f_cnt      <= '0;
                            words_left <= WL_W'(job_words(int'(cfg_dim), int'(cfg_num_filter), LANES));
                            state      <= ST_LOAD;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (emit) begin
                        if (filter_end) begin
                            w_cnt  <= '0;
                            f_cnt  <= f_cnt + NUM_W'(1);
                            last_q <= last_filter;
                        end else begin
                            w_cnt <= w_cnt + DIM_W'(1);
                        end
                    end
                    // Leave LOAD only once the final weight is on the outputs, so done trails it.
                    if (last_q) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
